// File: rtl/ozphy_os_gen_if.sv
// Request/response and PIPE receive-lane bundle for ozphy_os_gen.
// master = LTSSM/bench side, slave = the ordered-set generator.
interface ozphy_os_gen_if #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned CNT_W     = 16
) ();
  logic                   start;
  logic [1:0]             os_type;
  logic [CNT_W-1:0]       os_count;
  logic                   stop;
  logic [7:0]             link_num;
  logic                   link_pad;
  logic                   lane_pad;
  logic [7:0]             n_fts;
  logic [7:0]             train_ctrl;
  logic                   lane_rev;

  logic                   busy;
  logic                   done;
  logic [NUM_LANES*8-1:0] rxdata;
  logic [NUM_LANES-1:0]   rxdatak;
  logic [NUM_LANES-1:0]   rxvalid;
  logic [NUM_LANES-1:0]   rxelecidle;

  modport master (
    output start, os_type, os_count, stop, link_num, link_pad, lane_pad, n_fts, train_ctrl,
           lane_rev,
    input  busy, done, rxdata, rxdatak, rxvalid, rxelecidle
  );

  modport slave (
    input  start, os_type, os_count, stop, link_num, link_pad, lane_pad, n_fts, train_ctrl,
           lane_rev,
    output busy, done, rxdata, rxdatak, rxvalid, rxelecidle
  );
endinterface

// File: rtl/ozphy_os_gen.sv
// ozphy_os_gen: multi-lane PIPE rx ordered-set generator (TS1/TS2, logical idle, SKP).
// Define OZPHY_LANE_REVERSAL_EN to honour lane_rev in the TS lane-number symbol.
module ozphy_os_gen #(
  parameter int unsigned NUM_LANES    = 16,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter logic [7:0]  TS_RATE_ID   = 8'h02
) (
  input logic           clk,
  input logic           reset_n,
  ozphy_os_gen_if.slave bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StTs    = 3'd1;
  localparam logic [2:0] StLidle = 3'd2;
  localparam logic [2:0] StSkp   = 3'd3;
  localparam logic [2:0] StEnd   = 3'd4;

  localparam logic [7:0] SymCom = 8'hBC;
  localparam logic [7:0] SymPad = 8'hF7;
  localparam logic [7:0] SymSkp = 8'h1C;
  localparam logic [7:0] SymTs1 = 8'h4A;
  localparam logic [7:0] SymTs2 = 8'h45;

  // Control state
  logic [2:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [31:0]      skp_q, skp_d;
  logic             stop_q, stop_d;

  // Request fields captured at an accepted start
  logic [1:0]       type_q, type_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       link_q, link_d;
  logic             link_pad_q, link_pad_d;
  logic             lane_pad_q, lane_pad_d;
  logic [7:0]       nfts_q, nfts_d;
  logic [7:0]       tctrl_q, tctrl_d;
`ifdef OZPHY_LANE_REVERSAL_EN
  logic             rev_q, rev_d;
`endif

  // Registered outputs
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_LANES*8-1:0] rxdata_q, rxdata_d;
  logic [NUM_LANES-1:0]   rxdatak_q, rxdatak_d;
  logic [NUM_LANES-1:0]   rxvalid_q, rxvalid_d;
  logic [NUM_LANES-1:0]   rxelecidle_q, rxelecidle_d;

  logic [CNT_W-1:0] burst_inc;
  logic [31:0]      skp_inc;
  logic             count_end;
  logic             skp_due;
  logic             at_boundary;

  always_comb begin
    // Continuous bursts saturate instead of wrapping back to a matching count.
    burst_inc   = ((count_q == '0) && (burst_q == '1)) ? burst_q : burst_q + CNT_W'(1);
    skp_inc     = (skp_q == '1) ? skp_q : skp_q + 32'd1;
    count_end   = (count_q != '0) && (burst_inc == count_q);
    skp_due     = (SKP_INTERVAL != 0) && (skp_inc >= SKP_INTERVAL);
    at_boundary = (state_q == StLidle) || ((state_q == StTs) && (idx_q == 4'd15));
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    burst_d    = burst_q;
    skp_d      = skp_q;
    stop_d     = stop_q | bus.stop;
    type_d     = type_q;
    count_d    = count_q;
    link_d     = link_q;
    link_pad_d = link_pad_q;
    lane_pad_d = lane_pad_q;
    nfts_d     = nfts_q;
    tctrl_d    = tctrl_q;
`ifdef OZPHY_LANE_REVERSAL_EN
    rev_d      = rev_q;
`endif

    case (state_q)
      StIdle: begin
        idx_d   = '0;
        burst_d = '0;
        skp_d   = '0;
        stop_d  = 1'b0;
        if (bus.start) begin
          type_d     = bus.os_type;
          count_d    = bus.os_count;
          link_d     = bus.link_num;
          link_pad_d = bus.link_pad;
          lane_pad_d = bus.lane_pad;
          nfts_d     = bus.n_fts;
          tctrl_d    = bus.train_ctrl;
`ifdef OZPHY_LANE_REVERSAL_EN
          rev_d      = bus.lane_rev;
`endif
          case (bus.os_type)
            2'd0:    state_d = StEnd;
            2'd3:    state_d = StLidle;
            default: state_d = StTs;
          endcase
        end
      end

      StTs, StLidle: begin
        skp_d = skp_inc;
        idx_d = (state_q == StTs) ? idx_q + 4'd1 : 4'd0;
        if (at_boundary) begin
          burst_d = burst_inc;
          if (count_end || stop_d) begin
            // Burst end wins over a due SKP; the SKP count is left as it stood.
            state_d = StEnd;
            skp_d   = skp_q;
          end else if (skp_due) begin
            state_d = StSkp;
            skp_d   = '0;
            idx_d   = '0;
          end
        end
      end

      StSkp: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd3) begin
          idx_d   = '0;
          state_d = (type_q == 2'd3) ? StLidle : StTs;
        end
      end

      StEnd: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are the registered image of the current state and symbol index.
  always_comb begin
    logic [7:0] sym;
    logic       sym_k;
    logic [7:0] lane_id;

    busy_d       = 1'b0;
    done_d       = 1'b0;
    rxdata_d     = '0;
    rxdatak_d    = '0;
    rxvalid_d    = '0;
    rxelecidle_d = '1;
    sym          = 8'h00;
    sym_k        = 1'b0;
    lane_id      = 8'h00;

    case (state_q)
      StTs, StLidle, StSkp: begin
        busy_d       = 1'b1;
        rxvalid_d    = '1;
        rxelecidle_d = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
`ifdef OZPHY_LANE_REVERSAL_EN
          lane_id = rev_q ? 8'(NUM_LANES - 1 - i) : 8'(i);
`else
          lane_id = 8'(i);
`endif
          sym   = 8'h00;
          sym_k = 1'b0;
          if (state_q == StSkp) begin
            sym   = (idx_q == 4'd0) ? SymCom : SymSkp;
            sym_k = 1'b1;
          end else if (state_q == StTs) begin
            case (idx_q)
              4'd0: begin
                sym   = SymCom;
                sym_k = 1'b1;
              end
              4'd1: begin
                sym   = link_pad_q ? SymPad : link_q;
                sym_k = link_pad_q;
              end
              4'd2: begin
                sym   = lane_pad_q ? SymPad : lane_id;
                sym_k = lane_pad_q;
              end
              4'd3:    sym = nfts_q;
              4'd4:    sym = TS_RATE_ID;
              4'd5:    sym = tctrl_q;
              default: sym = (type_q == 2'd2) ? SymTs2 : SymTs1;
            endcase
          end
          rxdata_d[8*i +: 8] = sym;
          rxdatak_d[i]       = sym_k;
        end
      end

      StEnd: begin
        done_d = 1'b1;
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      burst_q      <= '0;
      skp_q        <= '0;
      stop_q       <= 1'b0;
      type_q       <= '0;
      count_q      <= '0;
      link_q       <= '0;
      link_pad_q   <= 1'b0;
      lane_pad_q   <= 1'b0;
      nfts_q       <= '0;
      tctrl_q      <= '0;
`ifdef OZPHY_LANE_REVERSAL_EN
      rev_q        <= 1'b0;
`endif
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rxdata_q     <= '0;
      rxdatak_q    <= '0;
      rxvalid_q    <= '0;
      rxelecidle_q <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      burst_q      <= burst_d;
      skp_q        <= skp_d;
      stop_q       <= stop_d;
      type_q       <= type_d;
      count_q      <= count_d;
      link_q       <= link_d;
      link_pad_q   <= link_pad_d;
      lane_pad_q   <= lane_pad_d;
      nfts_q       <= nfts_d;
      tctrl_q      <= tctrl_d;
`ifdef OZPHY_LANE_REVERSAL_EN
      rev_q        <= rev_d;
`endif
      busy_q       <= busy_d;
      done_q       <= done_d;
      rxdata_q     <= rxdata_d;
      rxdatak_q    <= rxdatak_d;
      rxvalid_q    <= rxvalid_d;
      rxelecidle_q <= rxelecidle_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rxdata     = rxdata_q;
  assign bus.rxdatak    = rxdatak_q;
  assign bus.rxvalid    = rxvalid_q;
  assign bus.rxelecidle = rxelecidle_q;

endmodule
